rle_encoder_param: RTL and testbench
====================================

# rle_encoder_param

Parametrised, single-clock run-length encoder for byte/word streams, successor to the fixed 8-bit two-clock RLE block. It has valid/ready handshakes on both sides, a configurable symbol width, escape symbol and minimum encoded run length. It handles runs longer than the count field, escape symbols in the input, and explicit end-of-stream flush. It sits between a symbol source and a packer or serialiser that may apply backpressure.

## Interface
- DATA_W, 8: symbol and count field width.
- ESC, 8'h1B (DATA_W bits): escape symbol.
- MIN_RUN, 4: shortest non-ESC run emitted as an escape triple. Legal range 2..MAX_RUN.
- MAX_RUN, 2^DATA_W-1 (derived, not overridable): largest count per triple.

- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  global clock-enable. Low freezes all state and forces Data_in_ready low.
- Data_in  in  DATA_W  input symbol.
- Data_in_valid  in  1  input symbol present.
- Data_in_ready  out  1  block accepts Data_in this cycle.
- Flush  in  1  level request: close and emit the pending run.
- Data_out  out  DATA_W  encoded output symbol.
- Data_out_valid  out  1  Data_out is valid.
- Data_out_ready  in  1  sink accepts Data_out.
- Busy  out  1  a run is accumulated or emission is in progress.

## Operation
- Output format:
  - Non-ESC run of length n with n < MIN_RUN: n literal copies of the symbol.
  - Non-ESC run with n ≥ MIN_RUN: ESC, n, sym.
  - ESC run of any length n ≥ 1: always ESC, n, ESC.
  - Count 0 is never emitted.
- Accumulator: cur_sym, cur_cnt (DATA_W bits), have_run.
- A symbol is accepted when Data_in_valid && Data_in_ready.
- States: IDLE, ACCUM, EMIT_ESC, EMIT_CNT, EMIT_SYM, EMIT_LIT. Held in an enum in rle_pkg.
- IDLE, on accept: cur_sym=Data_in, cur_cnt=1, go to ACCUM.
- ACCUM, on accept of an equal symbol with cur_cnt<MAX_RUN: increment cur_cnt.
- ACCUM, run close: caused by accept of a differing symbol, or an equal symbol with cur_cnt==MAX_RUN.
  - Copy (cur_sym, cur_cnt) to emit registers.
  - Restart the accumulator with Data_in and cnt=1.
  - Enter EMIT_ESC if the emitted symbol is ESC or the count ≥ MIN_RUN; otherwise enter EMIT_LIT.
- ACCUM with Flush high: no input accepted. Copy the run to emit registers, clear have_run, and on completion of emission return to IDLE.
- Flush in IDLE: no-op.
- Emission sequence:
  - EMIT_ESC → EMIT_CNT → EMIT_SYM → ACCUM (or IDLE if flushed). Each step advances on an output handshake.
  - EMIT_LIT outputs emit_sym emit_cnt times, then returns.
- Data_in_ready = Enable && !Flush && state∈{IDLE, ACCUM}. Input is never accepted during emission.
- Busy = have_run || state∉{IDLE, ACCUM}.

## Timing
- Reset values: Data_out=0, Data_out_valid=0, Data_in_ready=0, Busy=0, state=IDLE.
- Reset takes effect immediately on reset_n low, including mid-emission. The partial run and any partial triple are discarded.
- Output is registered. The first output symbol of a closed run is valid on the edge after the closing handshake (latency 1).
- Data_out and Data_out_valid hold stable while Data_out_valid && !Data_out_ready.
- With Data_out_ready held high, one output symbol is transferred per cycle.
- A triple occupies 3 cycles; a literal run occupies n cycles.
- Enable low: no state change. Outputs hold and in-flight handshakes are not completed.
- Counter arithmetic is DATA_W bits wide. No wrap is possible because close occurs at MAX_RUN.

## Structure
- rle_pkg holds:
  - the state enum;
  - the default ESC value;
  - a MIN_RUN legality check function.
- Sub-module rle_out_reg: the output holding register (Data_out, Data_out_valid, advance strobe), separating backpressure from the FSM.
- Top level: accumulator plus emission FSM.

## Test plan
- 'c'×4, 'b'×2, then Flush → 1B 04 63 62 62. Busy falls after the last handshake.
- 'h'×300 (DATA_W=8), then Flush → 1B FF 68 1B 2D 68.
- ESC, 'g', then Flush → 1B 01 1B 67. The next ESC, ESC pair → 1B 02 1B.
- Case 1 with Data_out_ready high one cycle in three → identical stream. Data_out is stable on every stalled cycle, and Data_in_ready is low throughout emission.
- reset_n pulsed low during EMIT_CNT of a 'c'×5 run → Data_out_valid=0 immediately, followed by Data_in_ready=1. Later input encodes from scratch.
- DATA_W=4, ESC=4'hF, MIN_RUN=3: input 5,5,5,F,F, then Flush → F 3 5 F 2 F.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the parametrised run-length encoder:
// FSM state encoding, default escape symbol and MIN_RUN legality check.
package rle_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ACCUM    = 3'd1,
      S_EMIT_ESC = 3'd2,
      S_EMIT_CNT = 3'd3,
      S_EMIT_SYM = 3'd4,
      S_EMIT_LIT = 3'd5
   } rle_state_t;

   localparam logic [7:0] ESC_DEFAULT = 8'h1B;

   // MIN_RUN must lie in 2 .. 2^data_w-1 (the largest count a triple can carry).
   function automatic bit min_run_ok(input int unsigned min_run, input int unsigned data_w);
      int unsigned max_run;
      if (data_w >= 32) begin
         return (min_run >= 32'd2);
      end
      max_run = (32'd1 << data_w) - 32'd1;
      return (min_run >= 32'd2) && (min_run <= max_run);
   endfunction

endpackage

// File: rtl/rle_out_reg.sv
// Output holding register. Holds Data_out/Data_out_valid stable under
// backpressure and reports each completed output handshake to the FSM.
module rle_out_reg
   import rle_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_enable,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_adv
);

   logic [DATA_W-1:0] r_data;
   logic              r_valid;

   assign o_data  = r_data;
   assign o_valid = r_valid;
   // A handshake only completes while the block is enabled.
   assign o_adv   = i_enable && r_valid && i_ready;

   // Load a new symbol, or drop valid once the last symbol has been taken.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_enable) begin
         if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (i_clear) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rle_encoder_param.sv
// Parametrised single-clock run-length encoder. Accumulates runs of equal
// symbols and emits them either as literals or as ESC,count,symbol triples.
module rle_encoder_param
   import rle_pkg::*;
#(
   parameter int unsigned       DATA_W  = 8,
   parameter logic [DATA_W-1:0] ESC     = DATA_W'(ESC_DEFAULT),
   parameter int unsigned       MIN_RUN = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              Enable,
   input  logic [DATA_W-1:0] Data_in,
   input  logic              Data_in_valid,
   output logic              Data_in_ready,
   input  logic              Flush,
   output logic [DATA_W-1:0] Data_out,
   output logic              Data_out_valid,
   input  logic              Data_out_ready,
   output logic              Busy
);

   localparam logic [DATA_W-1:0] MAX_RUN   = '1;
   localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
   localparam logic [DATA_W-1:0] MIN_RUN_W = DATA_W'(MIN_RUN);

   generate
      if (!min_run_ok(MIN_RUN, DATA_W)) begin : g_bad_min_run
         $error("rle_encoder_param: MIN_RUN out of range 2..2^DATA_W-1");
      end
   endgenerate

   rle_state_t        r_state,     w_state_nx;
   logic [DATA_W-1:0] r_cur_sym,   w_cur_sym_nx;
   logic [DATA_W-1:0] r_cur_cnt,   w_cur_cnt_nx;
   logic              r_have_run,  w_have_run_nx;
   logic [DATA_W-1:0] r_emit_sym,  w_emit_sym_nx;
   logic [DATA_W-1:0] r_emit_cnt,  w_emit_cnt_nx;
   logic [DATA_W-1:0] r_lit_left,  w_lit_left_nx;
   logic              r_live;

   logic              w_in_state;
   logic              w_accept;
   logic              w_close;
   logic              w_ld;
   logic              w_clr;
   logic [DATA_W-1:0] w_ld_data;
   logic              w_adv;

   assign w_in_state    = (r_state == S_IDLE) || (r_state == S_ACCUM);
   // r_live keeps Data_in_ready low while reset is applied and for the first edge after it.
   assign Data_in_ready = r_live && Enable && !Flush && w_in_state;
   assign w_accept      = Data_in_ready && Data_in_valid;
   assign Busy          = r_have_run || !w_in_state;

   // Marks the first clock after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
      end
   end

   // State and datapath registers; everything freezes while Enable is low.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_cur_sym  <= '0;
         r_cur_cnt  <= '0;
         r_have_run <= 1'b0;
         r_emit_sym <= '0;
         r_emit_cnt <= '0;
         r_lit_left <= '0;
      end else if (Enable) begin
         r_state    <= w_state_nx;
         r_cur_sym  <= w_cur_sym_nx;
         r_cur_cnt  <= w_cur_cnt_nx;
         r_have_run <= w_have_run_nx;
         r_emit_sym <= w_emit_sym_nx;
         r_emit_cnt <= w_emit_cnt_nx;
         r_lit_left <= w_lit_left_nx;
      end
   end

   // Next-state, accumulator update and output-register load control.
   always_comb begin
      w_state_nx    = r_state;
      w_cur_sym_nx  = r_cur_sym;
      w_cur_cnt_nx  = r_cur_cnt;
      w_have_run_nx = r_have_run;
      w_emit_sym_nx = r_emit_sym;
      w_emit_cnt_nx = r_emit_cnt;
      w_lit_left_nx = r_lit_left;
      w_close       = 1'b0;
      w_ld          = 1'b0;
      w_clr         = 1'b0;
      w_ld_data     = '0;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cur_sym_nx  = Data_in;
               w_cur_cnt_nx  = ONE;
               w_have_run_nx = 1'b1;
               w_state_nx    = S_ACCUM;
            end
         end

         S_ACCUM: begin
            if (Enable && Flush) begin
               w_close       = 1'b1;
               w_have_run_nx = 1'b0;
            end else if (w_accept) begin
               if ((Data_in == r_cur_sym) && (r_cur_cnt != MAX_RUN)) begin
                  w_cur_cnt_nx = r_cur_cnt + ONE;
               end else begin
                  w_close      = 1'b1;
                  w_cur_sym_nx = Data_in;
                  w_cur_cnt_nx = ONE;
               end
            end
         end

         S_EMIT_ESC: begin
            if (w_adv) begin
               w_ld       = 1'b1;
               w_ld_data  = r_emit_cnt;
               w_state_nx = S_EMIT_CNT;
            end
         end

         S_EMIT_CNT: begin
            if (w_adv) begin
               w_ld       = 1'b1;
               w_ld_data  = r_emit_sym;
               w_state_nx = S_EMIT_SYM;
            end
         end

         S_EMIT_SYM: begin
            if (w_adv) begin
               w_clr      = 1'b1;
               w_state_nx = r_have_run ? S_ACCUM : S_IDLE;
            end
         end

         S_EMIT_LIT: begin
            if (w_adv) begin
               if (r_lit_left == '0) begin
                  w_clr      = 1'b1;
                  w_state_nx = r_have_run ? S_ACCUM : S_IDLE;
               end else begin
                  w_ld          = 1'b1;
                  w_ld_data     = r_emit_sym;
                  w_lit_left_nx = r_lit_left - ONE;
               end
            end
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase

      // Closing a run presents its first output symbol on the very next edge;
      // r_lit_left counts literal copies still owed after the one being loaded.
      if (w_close) begin
         w_emit_sym_nx = r_cur_sym;
         w_emit_cnt_nx = r_cur_cnt;
         w_ld          = 1'b1;
         if ((r_cur_sym == ESC) || (r_cur_cnt >= MIN_RUN_W)) begin
            w_ld_data  = ESC;
            w_state_nx = S_EMIT_ESC;
         end else begin
            w_ld_data     = r_cur_sym;
            w_lit_left_nx = r_cur_cnt - ONE;
            w_state_nx    = S_EMIT_LIT;
         end
      end
   end

   rle_out_reg #(
      .DATA_W (DATA_W)
   ) u_out_reg (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_enable (Enable),
      .i_load   (w_ld),
      .i_clear  (w_clr),
      .i_data   (w_ld_data),
      .i_ready  (Data_out_ready),
      .o_data   (Data_out),
      .o_valid  (Data_out_valid),
      .o_adv    (w_adv)
   );

endmodule

// File: tb/tb_rle_encoder_param.sv
// Directed testbench for rle_encoder_param (8-bit default and 4-bit variant).
module tb_rle_encoder_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic       vin = 1'b0;
   logic [7:0] din = '0;
   logic       in_rdy, ovalid, busy, oready;
   logic [7:0] dout;

   logic       flush4 = 1'b0;
   logic       vin4 = 1'b0;
   logic [3:0] din4 = '0;
   logic       oready4 = 1'b1;
   logic       in_rdy4, ovalid4, busy4;
   logic [3:0] dout4;

   int n_cmp = 0;
   int n_fail = 0;

   // rmode: 0 always ready, 1 ready one cycle in three, 2 never, 3 manual
   int   rmode = 0;
   int   ph = 0;
   logic man_rdy = 1'b0;
   assign oready = (rmode == 0) || (rmode == 1 && ph == 0) || (rmode == 3 && man_rdy);

   logic [7:0] q[$];
   logic [3:0] q4[$];
   int         stall_chk = 0;
   int         stall_err = 0;
   int         rdy_err = 0;
   logic       stall_pend = 1'b0;
   logic [7:0] stall_data = '0;

   always #5 clk = ~clk;

   rle_encoder_param u_dut (
      .clock          (clk),
      .reset_n        (rst_n),
      .Enable         (en),
      .Data_in        (din),
      .Data_in_valid  (vin),
      .Data_in_ready  (in_rdy),
      .Flush          (flush),
      .Data_out       (dout),
      .Data_out_valid (ovalid),
      .Data_out_ready (oready),
      .Busy           (busy)
   );

   rle_encoder_param #(
      .DATA_W  (4),
      .ESC     (4'hF),
      .MIN_RUN (3)
   ) u_dut4 (
      .clock          (clk),
      .reset_n        (rst_n),
      .Enable         (en),
      .Data_in        (din4),
      .Data_in_valid  (vin4),
      .Data_in_ready  (in_rdy4),
      .Flush          (flush4),
      .Data_out       (dout4),
      .Data_out_valid (ovalid4),
      .Data_out_ready (oready4),
      .Busy           (busy4)
   );

   // Ready-pattern phase, advanced just after each rising edge.
   always @(posedge clk) begin
      #1;
      ph = (ph == 2) ? 0 : ph + 1;
   end

   // Output collector and stability watcher, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n && en && ovalid && oready) q.push_back(dout);
      if (rst_n && en && ovalid4 && oready4) q4.push_back(dout4);
      if (rst_n && stall_pend) begin
         stall_chk++;
         if (!ovalid || dout !== stall_data) stall_err++;
      end
      stall_pend = rst_n && ovalid && !oready;
      stall_data = dout;
      if (rst_n && ovalid && in_rdy) rdy_err++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [7:0] s);
      bit ok;
      ok = 0;
      din = s;
      vin = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (in_rdy) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      vin = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL send_timeout: got no_accept required accept (sym %02h)", s);
      end
   endtask

   task automatic flush_wait();
      bit ok;
      ok = 0;
      flush = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL flush_timeout: got busy=1 required busy=0");
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      #12;
      n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", ovalid); end
      n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_dout: got %h required 00", dout); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_rdy); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b required 1", in_rdy); end
   endtask

   task automatic test_basic();
      logic [7:0] exp[$];
      logic [7:0] got;
      exp = '{8'h1B, 8'h04, 8'h63, 8'h62, 8'h62};
      q.delete();
      repeat (4) send(8'h63);
      repeat (2) send(8'h62);
      flush_wait();
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL basic_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL basic_sym%0d: got %h required %h", i, got, exp[i]); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b required 0", busy); end
      n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL basic_valid: got %b required 0", ovalid); end
   endtask

   task automatic test_long_run();
      logic [7:0] exp[$];
      logic [7:0] got;
      exp = '{8'h1B, 8'hFF, 8'h68, 8'h1B, 8'h2D, 8'h68};
      q.delete();
      repeat (300) send(8'h68);
      flush_wait();
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL long_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL long_sym%0d: got %h required %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_escape();
      logic [7:0] exp[$];
      logic [7:0] got;
      exp = '{8'h1B, 8'h01, 8'h1B, 8'h67};
      q.delete();
      send(8'h1B);
      send(8'h67);
      flush_wait();
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL esc1_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL esc1_sym%0d: got %h required %h", i, got, exp[i]); end
      end
      exp = '{8'h1B, 8'h02, 8'h1B};
      q.delete();
      send(8'h1B);
      send(8'h1B);
      flush_wait();
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL esc2_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL esc2_sym%0d: got %h required %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp[$];
      logic [7:0] got;
      exp = '{8'h1B, 8'h04, 8'h63, 8'h62, 8'h62};
      q.delete();
      stall_chk = 0;
      stall_err = 0;
      rdy_err = 0;
      rmode = 1;
      repeat (4) send(8'h63);
      repeat (2) send(8'h62);
      flush_wait();
      rmode = 0;
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL bp_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL bp_sym%0d: got %h required %h", i, got, exp[i]); end
      end
      n_cmp++; if (stall_chk == 0) begin n_fail++; $display("FAIL bp_stalls_seen: got %0d required >0", stall_chk); end
      n_cmp++; if (stall_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles required 0", stall_err); end
      n_cmp++; if (rdy_err !== 0) begin n_fail++; $display("FAIL bp_in_ready_low: got %0d cycles high required 0", rdy_err); end
   endtask

   task automatic test_enable();
      logic [7:0] exp[$];
      logic [7:0] got;
      exp = '{8'h1B, 8'h04, 8'h63, 8'h62, 8'h62};
      q.delete();
      repeat (4) send(8'h63);
      send(8'h62);
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_cmp++; if (ovalid !== 1'b1 || dout !== 8'h1B) begin n_fail++; $display("FAIL en_hold%0d: got v=%b d=%h required v=1 d=1b", c, ovalid, dout); end
         n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL en_in_ready%0d: got %b required 0", c, in_rdy); end
      end
      n_cmp++; if (q.size() !== 0) begin n_fail++; $display("FAIL en_no_xfer: got %0d required 0", q.size()); end
      @(posedge clk);
      #1;
      en = 1'b1;
      send(8'h62);
      flush_wait();
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL en_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL en_sym%0d: got %h required %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp[$];
      logic [7:0] got;
      bit ok;
      exp = '{8'h61, 8'h61};
      rmode = 3;
      man_rdy = 1'b0;
      repeat (5) send(8'h63);
      flush = 1'b1;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ovalid) begin
            ok = 1;
            break;
         end
      end
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL mid_esc_valid: got 0 required 1"); end
      man_rdy = 1'b1;
      @(posedge clk);
      #1;
      man_rdy = 1'b0;
      n_cmp++; if (ovalid !== 1'b1 || dout !== 8'h05) begin n_fail++; $display("FAIL mid_cnt: got v=%b d=%h required v=1 d=05", ovalid, dout); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b required 0", ovalid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
      n_cmp++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b required 0", in_rdy); end
      flush = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_cmp++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready_after: got %b required 1", in_rdy); end
      rmode = 0;
      q.delete();
      send(8'h61);
      send(8'h61);
      flush_wait();
      n_cmp++; if (q.size() !== exp.size()) begin n_fail++; $display("FAIL mid_after_len: got %0d required %0d", q.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL mid_after_sym%0d: got %h required %h", i, got, exp[i]); end
      end
   endtask

   task automatic test_width4();
      logic [3:0] stim[$];
      logic [3:0] exp[$];
      logic [3:0] got;
      bit ok;
      stim = '{4'h5, 4'h5, 4'h5, 4'hF, 4'hF};
      exp  = '{4'hF, 4'h3, 4'h5, 4'hF, 4'h2, 4'hF};
      q4.delete();
      for (int s = 0; s < stim.size(); s++) begin
         ok = 0;
         din4 = stim[s];
         vin4 = 1'b1;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_rdy4) begin
               ok = 1;
               break;
            end
         end
         @(posedge clk);
         #1;
         vin4 = 1'b0;
         n_cmp++; if (!ok) begin n_fail++; $display("FAIL w4_accept%0d: got no_accept required accept", s); end
      end
      flush4 = 1'b1;
      ok = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy4) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      flush4 = 1'b0;
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL w4_flush: got busy=1 required busy=0"); end
      n_cmp++; if (q4.size() !== exp.size()) begin n_fail++; $display("FAIL w4_len: got %0d required %0d", q4.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         got = (i < q4.size()) ? q4[i] : 4'hx;
         n_cmp++; if (got !== exp[i]) begin n_fail++; $display("FAIL w4_sym%0d: got %h required %h", i, got, exp[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_long_run();
      test_escape();
      test_backpressure();
      test_enable();
      test_reset_mid();
      test_width4();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
